// File: rtl/eth_rx.sv
// RMII receive path: preamble/SFD detect, destination filter, header capture,
// payload streaming with FCS stripped, CRC-32 and length checks.
module eth_rx #(
  parameter logic [47:0] pMAC_ADDR  = 48'h020000000001,
  parameter int          pMIN_FRAME = 64,
  parameter int          pMAX_FRAME = 1518
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [1:0]  Rx_Data,
  input  logic        Crs_Dv,
  output logic [7:0]  Rx_Byte,
  output logic        Rx_Byte_Valid,
  output logic [47:0] Rx_Src_Addr,
  output logic [15:0] Rx_Len_Type,
  output logic        Rx_Hdr_Valid,
  output logic        Rx_Pkt_Done,
  output logic        Rx_Pkt_Err
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA, DROP
  } state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] BCNT_MIN    = 11'(pMIN_FRAME);
  localparam logic [10:0] BCNT_MAX    = 11'(pMAX_FRAME);
  localparam logic [10:0] BCNT_SAT    = 11'(pMAX_FRAME + 1);

  state_t          state, state_nxt;
  logic            crs_q;
  logic [7:0]      sh;
  logic [1:0]      dcnt;
  logic [10:0]     bcnt;
  logic [31:0]     crc;
  logic [3:0][7:0] dl;
  logic [2:0]      fill;
  logic            bc_ok, uc_ok, oversize;
  logic [47:0]     src_sh;
  logic [7:0]      lt_hi;

  logic            in_frame, dibit, byte_done, bc_ok_nxt, uc_ok_nxt, frame_err, sfd;
  logic [7:0]      new_byte, mac_byte;
  logic [10:0]     bcnt_nxt;

  // Reflected CRC-32, wire bit 0 of the dibit is shifted in first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
    return r;
  endfunction

  always_comb begin
    in_frame  = (state == DEST_ADDR) || (state == SRC_ADDR) ||
                (state == LEN_TYPE)  || (state == DATA);
    dibit     = in_frame && Crs_Dv;
    byte_done = dibit && (dcnt == 2'd3);
    sfd       = (state == PREAMBLE) && Crs_Dv && (Rx_Data == 2'b11);
    new_byte  = {Rx_Data, sh[7:2]};
    bcnt_nxt  = (bcnt == BCNT_SAT) ? bcnt : bcnt + 11'd1;
    mac_byte  = 8'(pMAC_ADDR >> {3'(3'd5 - bcnt[2:0]), 3'b000});
    bc_ok_nxt = bc_ok && (new_byte == 8'hFF);
    uc_ok_nxt = uc_ok && (new_byte == mac_byte);
    frame_err = (crc != CRC_RESIDUE) || (bcnt < BCNT_MIN) || (dcnt != 2'd0) || oversize;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (Crs_Dv && !crs_q && (Rx_Data == 2'b01)) state_nxt = PREAMBLE;
      PREAMBLE: begin
        if (!Crs_Dv)                state_nxt = IDLE;
        else if (Rx_Data == 2'b11)  state_nxt = DEST_ADDR;
        else if (Rx_Data != 2'b01)  state_nxt = DROP;
      end
      DEST_ADDR: begin
        if (!Crs_Dv) state_nxt = IDLE;
        else if (byte_done && (bcnt == 11'd5))
          state_nxt = (bc_ok_nxt || uc_ok_nxt) ? SRC_ADDR : DROP;
      end
      SRC_ADDR: begin
        if (!Crs_Dv) state_nxt = IDLE;
        else if (byte_done && (bcnt == 11'd11)) state_nxt = LEN_TYPE;
      end
      LEN_TYPE: begin
        if (!Crs_Dv) state_nxt = IDLE;
        else if (byte_done && (bcnt == 11'd13)) state_nxt = DATA;
      end
      DATA: begin
        if (!Crs_Dv) state_nxt = IDLE;
        else if (byte_done && (bcnt_nxt > BCNT_MAX)) state_nxt = DROP;
      end
      DROP:      if (!Crs_Dv) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      // crs_q starts high so a frame already on the wire at reset is ignored.
      crs_q         <= 1'b1;
      sh            <= '0;
      dcnt          <= '0;
      bcnt          <= '0;
      crc           <= 32'hFFFFFFFF;
      dl            <= '0;
      fill          <= '0;
      bc_ok         <= 1'b0;
      uc_ok         <= 1'b0;
      oversize      <= 1'b0;
      src_sh        <= '0;
      lt_hi         <= '0;
      Rx_Byte       <= '0;
      Rx_Byte_Valid <= 1'b0;
      Rx_Src_Addr   <= '0;
      Rx_Len_Type   <= '0;
      Rx_Hdr_Valid  <= 1'b0;
      Rx_Pkt_Done   <= 1'b0;
      Rx_Pkt_Err    <= 1'b0;
    end else begin
      crs_q         <= Crs_Dv;
      Rx_Byte_Valid <= 1'b0;
      Rx_Hdr_Valid  <= 1'b0;
      Rx_Pkt_Done   <= 1'b0;
      Rx_Pkt_Err    <= 1'b0;
      if (sfd) begin
        crc      <= 32'hFFFFFFFF;
        dcnt     <= '0;
        bcnt     <= '0;
        fill     <= '0;
        bc_ok    <= 1'b1;
        uc_ok    <= 1'b1;
        oversize <= 1'b0;
      end
      if (dibit) begin
        sh   <= new_byte;
        dcnt <= dcnt + 2'd1;
        crc  <= crc_dibit(crc, Rx_Data);
      end
      if (byte_done) begin
        bcnt <= bcnt_nxt;
        case (state)
          DEST_ADDR: begin
            bc_ok <= bc_ok_nxt;
            uc_ok <= uc_ok_nxt;
          end
          SRC_ADDR: src_sh <= {src_sh[39:0], new_byte};
          LEN_TYPE: begin
            if (bcnt == 11'd12) lt_hi <= new_byte;
            else begin
              Rx_Src_Addr  <= src_sh;
              Rx_Len_Type  <= {lt_hi, new_byte};
              Rx_Hdr_Valid <= 1'b1;
            end
          end
          DATA: begin
            // Four-byte delay line keeps the FCS from ever reaching the consumer.
            if (bcnt_nxt > BCNT_MAX) oversize <= 1'b1;
            else begin
              dl <= {dl[2:0], new_byte};
              if (fill == 3'd4) begin
                Rx_Byte       <= dl[3];
                Rx_Byte_Valid <= 1'b1;
              end else begin
                fill <= fill + 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
      if (!Crs_Dv) begin
        case (state)
          DATA: begin
            Rx_Pkt_Done <= 1'b1;
            Rx_Pkt_Err  <= frame_err;
          end
          DEST_ADDR, SRC_ADDR, LEN_TYPE: begin
            Rx_Pkt_Done <= 1'b1;
            Rx_Pkt_Err  <= 1'b1;
          end
          DROP: begin
            Rx_Pkt_Done <= oversize;
            Rx_Pkt_Err  <= oversize;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
